// File: rtl/full_adder_unit.sv
// Parameterised ripple-carry adder built from per-bit full-adder cells.
// Offers a combinational result and a one-cycle registered copy qualified by out_valid.
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c,
  output logic             cout_c,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the final carry-out.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic p;
    assign p          = a[i] ^ b[i];
    assign sum_c[i]   = p ^ c[i];
    assign c[i+1]     = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout_c = c[WIDTH];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_c;
      cout      <= cout_c;
      out_valid <= 1'b1;
    end else begin
      // Data is held for late readers but no longer flagged valid.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH=1, 8 and 32 using directed
// vector tables, hand-written multi-cycle sequences and bench-computed random sums.
module tb_full_adder_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v1,  a1,  b1,  c1,  s1c,  co1c,  s1,  co1,  ov1;
  logic        v8,  c8,  co8c,  co8,  ov8;
  logic [7:0]  a8,  b8,  s8c,  s8;
  logic        v32, c32, co32c, co32, ov32;
  logic [31:0] a32, b32, s32c, s32;

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum_c(s1c), .cout_c(co1c), .sum(s1), .cout(co1), .out_valid(ov1));

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .sum_c(s8c), .cout_c(co8c), .sum(s8), .cout(co8), .out_valid(ov8));

  full_adder_unit #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(v32), .a(a32), .b(b32), .cin(c32),
    .sum_c(s32c), .cout_c(co32c), .sum(s32), .cout(co32), .out_valid(ov32));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t t1[8];
  vec_t t8[3];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  e1;
    logic [8:0]  e8;
    logic [32:0] e32;

    t1[0] = '{a: 0, b: 0, cin: 0, s: 0, co: 0};
    t1[1] = '{a: 0, b: 0, cin: 1, s: 1, co: 0};
    t1[2] = '{a: 0, b: 1, cin: 0, s: 1, co: 0};
    t1[3] = '{a: 0, b: 1, cin: 1, s: 0, co: 1};
    t1[4] = '{a: 1, b: 0, cin: 0, s: 1, co: 0};
    t1[5] = '{a: 1, b: 0, cin: 1, s: 0, co: 1};
    t1[6] = '{a: 1, b: 1, cin: 0, s: 0, co: 1};
    t1[7] = '{a: 1, b: 1, cin: 1, s: 1, co: 1};

    t8[0] = '{a: 32'hFF, b: 32'h00, cin: 1, s: 32'h00, co: 1};
    t8[1] = '{a: 32'h7F, b: 32'h01, cin: 0, s: 32'h80, co: 0};
    t8[2] = '{a: 32'hFF, b: 32'hFF, cin: 1, s: 32'hFF, co: 1};

    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v32 = 0; a32 = 0; b32 = 0; c32 = 0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_w1_sum", s1, 0);   check("rst_w1_cout", co1, 0);   check("rst_w1_ov", ov1, 0);
    check("rst_w8_sum", s8, 0);   check("rst_w8_ov", ov8, 0);
    check("rst_w32_sum", s32, 0); check("rst_w32_ov", ov32, 0);

    // Outputs stay at zero until the first accepted input
    step();
    check("post_rst_w1_ov", ov1, 0);
    check("post_rst_w1_sum", s1, 0);

    // Exhaustive WIDTH=1 truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      v1 = 1; a1 = t1[i].a[0]; b1 = t1[i].b[0]; c1 = t1[i].cin;
      #1;
      check($sformatf("tt%0d_sum_c", i), s1c, t1[i].s);
      check($sformatf("tt%0d_cout_c", i), co1c, t1[i].co);
      step();
      check($sformatf("tt%0d_sum", i), s1, t1[i].s);
      check($sformatf("tt%0d_cout", i), co1, t1[i].co);
      check($sformatf("tt%0d_ov", i), ov1, 1);
    end
    v1 = 0;
    step();

    // Hold: accept 1+1+1, then idle with zero operands for 3 cycles
    v1 = 1; a1 = 1; b1 = 1; c1 = 1;
    step();
    check("hold_sum0", s1, 1); check("hold_cout0", co1, 1); check("hold_ov0", ov1, 1);
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    #1;
    check("hold_sum_c", s1c, 0); check("hold_cout_c", co1c, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("hold%0d_sum", k), s1, 1);
      check($sformatf("hold%0d_cout", k), co1, 1);
      check($sformatf("hold%0d_ov", k), ov1, 0);
    end

    // Reset priority over in_valid
    rst = 1; v1 = 1; a1 = 1; b1 = 1; c1 = 0;
    #1;
    check("rstpri_sum_c", s1c, 0); check("rstpri_cout_c", co1c, 1);
    step();
    check("rstpri_sum", s1, 0); check("rstpri_cout", co1, 0); check("rstpri_ov", ov1, 0);
    rst = 0; v1 = 0;
    step();
    check("rstpri_after_ov", ov1, 0);

    // WIDTH=8 wrap table
    for (int i = 0; i < 3; i++) begin
      v8 = 1; a8 = t8[i].a[7:0]; b8 = t8[i].b[7:0]; c8 = t8[i].cin;
      #1;
      check($sformatf("wrap%0d_sum_c", i), s8c, t8[i].s);
      check($sformatf("wrap%0d_cout_c", i), co8c, t8[i].co);
      step();
      check($sformatf("wrap%0d_sum", i), s8, t8[i].s);
      check($sformatf("wrap%0d_cout", i), co8, t8[i].co);
      check($sformatf("wrap%0d_ov", i), ov8, 1);
    end
    v8 = 0;
    step();

    // Back-to-back WIDTH=8 stream, then reset mid-stream
    v8 = 1; a8 = 8'h01; b8 = 8'h02; c8 = 0;
    step();
    check("b2b0_sum", s8, 8'h03); check("b2b0_cout", co8, 0); check("b2b0_ov", ov8, 1);
    a8 = 8'h03; b8 = 8'h04; c8 = 1;
    step();
    check("b2b1_sum", s8, 8'h08); check("b2b1_cout", co8, 0); check("b2b1_ov", ov8, 1);
    a8 = 8'h80; b8 = 8'h80; c8 = 0;
    step();
    check("b2b2_sum", s8, 8'h00); check("b2b2_cout", co8, 1); check("b2b2_ov", ov8, 1);
    rst = 1; a8 = 8'h11; b8 = 8'h22; c8 = 1;
    step();
    check("midrst_ov", ov8, 0); check("midrst_sum", s8, 0); check("midrst_cout", co8, 0);
    rst = 0; v8 = 0;
    step();

    // Random vectors at all three widths, expected sums computed at WIDTH+1 bits
    for (int i = 0; i < 1000; i++) begin
      v1 = 1; a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v8 = 1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      v32 = 1; a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
      e1  = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
      e8  = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
      e32 = {1'b0, a32} + {1'b0, b32} + {32'b0, c32};
      #1;
      check("rnd_w1_comb", {co1c, s1c}, e1);
      check("rnd_w8_comb", {co8c, s8c}, e8);
      check("rnd_w32_comb", {co32c, s32c}, e32);
      step();
      check("rnd_w1_reg", {ov1, co1, s1}, {1'b1, e1});
      check("rnd_w8_reg", {ov8, co8, s8}, {1'b1, e8});
      check("rnd_w32_reg", {ov32, co32, s32}, {1'b1, e32});
    end
    v1 = 0; v8 = 0; v32 = 0;
    step();
    check("end_w32_ov", ov32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Parameterised ripple-carry adder built from per-bit full-adder cells; computes {cout, sum} = a + b + cin.
- Provides combinational results for immediate use and a one-cycle registered copy with a valid flag for pipelined datapaths.
- The default WIDTH=1 is the classic single-bit full adder used across the arithmetic blocks.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1 to 64.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  qualifies a, b and cin for capture into the output register.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- sum_c  output  WIDTH  combinational sum, low WIDTH bits of a+b+cin.
- cout_c  output  1  combinational carry-out, bit WIDTH of a+b+cin.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry-out.
- out_valid  output  1  high for the cycle after an accepted input.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst. No asynchronous reset paths.
- Per-bit cell i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - c[0] = cin; cout_c = c[WIDTH]; sum_c = s.
- Combinational path: sum_c and cout_c depend only on a, b and cin. They ignore clk, rst and in_valid, and settle in the same delta as the inputs.
- Required truth table for WIDTH=1, given as (a, b, cin) -> (sum, cout):
  - 000->00, 001->10, 010->10, 011->01
  - 100->10, 101->01, 110->01, 111->11
- Arithmetic:
  - Operands are unsigned; the result is exactly WIDTH+1 bits with no saturation.
  - Overflow appears only as cout=1; sum wraps modulo 2^WIDTH.
- Registered path, on each rising clk edge:
  - If rst=1: sum<=0, cout<=0, out_valid<=0. Reset takes priority over in_valid.
  - Else if in_valid=1: sum<=sum_c, cout<=cout_c, out_valid<=1.
  - Else: sum and cout hold their previous values; out_valid<=0.
- Latency: 1 cycle from an accepted input to registered output.
- Throughput: one result per cycle; back-to-back in_valid is supported with no bubbles.
- No backpressure: downstream must consume the result in the cycle out_valid=1. The data stays held afterwards but is no longer flagged valid.
- Reset behaviour:
  - After reset deasserts, outputs remain 0 until the first accepted input.
  - Reset asserted in the same cycle as in_valid discards that input.
  - Reset mid-stream clears out_valid on the following edge.
- X-propagation: no special handling; X on inputs propagates to outputs.

Test Plan:
- Exhaustive WIDTH=1 check: apply all 8 (a, b, cin) combinations, each for 10 ns with in_valid=1.
  - sum_c/cout_c must match the truth table above.
  - sum/cout must match one cycle later, with out_valid=1.
- Hold check: a=1, b=1, cin=1 accepted, then in_valid=0 with a=0, b=0, cin=0 for 3 cycles.
  - sum=1 and cout=1 hold; out_valid=0 after the first cycle.
  - sum_c=0 and cout_c=0 immediately.
- Reset priority: rst=1 together with in_valid=1 and a=1, b=1, cin=0.
  - Next edge: sum=0, cout=0, out_valid=0.
  - Comb outputs still read sum_c=0, cout_c=1.
- WIDTH=8 wrap: a=0xFF, b=0x00, cin=1 -> sum_c=0x00, cout_c=1; a=0x7F, b=0x01, cin=0 -> 0x80, cout=0; a=0xFF, b=0xFF, cin=1 -> 0xFF, cout=1.
- Back-to-back: WIDTH=8, stream (1,2,0), (3,4,1), (0x80,0x80,0) on consecutive cycles.
  - Registered outputs are 0x03/0, 0x08/0, 0x00/1 on consecutive cycles, with out_valid continuously 1.
- Random: 1000 random vectors at WIDTH=1, 8 and 32, compared against a+b+cin computed as WIDTH+1 bits in the bench.
